sat_pred_table: RTL and testbench

SAT_PRED_TABLE -- requirements
Module: sat_pred_table

---
 rtl/sat_pred_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/sat_pred_table.sv | 89 ++++++++
 tb/tb_sat_pred_table.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sat_pred_pkg.sv
// Shared defaults and the saturating-counter step function for the branch predictor table.
package sat_pred_pkg;

    localparam int DEF_CNT_W  = 2;
    localparam int DEF_IDX_W  = 4;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_STAT_W = 16;

    // Next counter value: move toward max_val on taken, toward 0 otherwise, clamping at both ends.
    function automatic int unsigned sat_next(input int unsigned cur,
                                             input logic        taken,
                                             input int unsigned max_val);
        if (taken) begin
            return (cur >= max_val) ? max_val : cur + 1;
        end
        return (cur == 0) ? 0 : cur - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// One CNT_W-bit saturating direction counter; steps only when enable is high.
module sat_counter
    import sat_pred_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             taken,
    output logic [CNT_W-1:0] value
);

    localparam int unsigned MAX_VAL = (1 << CNT_W) - 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (enable) begin
            value <= CNT_W'(sat_next(32'(value), taken, MAX_VAL));
        end
    end

endmodule

// File: rtl/sat_pred_table.sv
// Table of saturating counters predicting branch direction, with mispredict statistics.
// Define SAT_PRED_GSHARE_EN for gshare indexing (PC bits XOR global history); default is bimodal.
module sat_pred_table
    import sat_pred_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              prediction,
    input  logic              branch,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [IDX_W-1:0] lookup_base;
    logic [IDX_W-1:0] upd_base;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] ctr [DEPTH];
    logic             upd_msb;
    logic             miss;
    logic             unused_pc;

    // Word-aligned PCs: the two low bits carry no information.
    assign lookup_base = lookup_pc[IDX_W+1:2];
    assign upd_base    = upd_pc[IDX_W+1:2];
    assign unused_pc   = ^{lookup_pc, upd_pc};

`ifdef SAT_PRED_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign lookup_idx = lookup_base ^ ghr;
    assign upd_idx    = upd_base ^ ghr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (branch) begin
            ghr <= {ghr[IDX_W-2:0], taken};
        end
    end
`else
    assign lookup_idx = lookup_base;
    assign upd_idx    = upd_base;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic hit;
            assign hit = branch && (upd_idx == IDX_W'(gi));
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_ctr (
                .clk    (clk),
                .reset  (reset),
                .enable (hit),
                .taken  (taken),
                .value  (ctr[gi])
            );
        end
    endgenerate

    // Reads see the table before this cycle's update lands.
    assign prediction = ctr[lookup_idx][CNT_W-1];
    assign upd_msb    = ctr[upd_idx][CNT_W-1];
    assign miss       = branch && (taken != upd_msb);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict     <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            mispredict <= miss;
            if (miss && (mispredict_cnt != {STAT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sat_pred_table.sv
// Directed bench for sat_pred_table: default instance plus a CNT_W=1, STAT_W=2 instance for saturation.
module tb_sat_pred_table;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        prediction;
    logic        branch;
    logic [31:0] upd_pc;
    logic        taken;
    logic        mispredict;
    logic [15:0] mispredict_cnt;

    logic [31:0] lookup_pc2;
    logic        prediction2;
    logic        branch2;
    logic [31:0] upd_pc2;
    logic        taken2;
    logic        mispredict2;
    logic [1:0]  mispredict_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sat_pred_table u_dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .prediction     (prediction),
        .branch         (branch),
        .upd_pc         (upd_pc),
        .taken          (taken),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    sat_pred_table #(
        .CNT_W  (1),
        .STAT_W (2)
    ) u_dut2 (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc2),
        .prediction     (prediction2),
        .branch         (branch2),
        .upd_pc         (upd_pc2),
        .taken          (taken2),
        .mispredict     (mispredict2),
        .mispredict_cnt (mispredict_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rst_pcs [5] = '{32'h0, 32'h4, 32'h10, 32'h3c, 32'h50};
        int wp [4] = '{0, 1, 1, 1};
        int wm [4] = '{1, 1, 0, 0};
        int wc [4] = '{1, 2, 2, 2};
        int dp [4] = '{1, 0, 0, 0};
        int dm [4] = '{1, 1, 0, 0};
        int dc [4] = '{3, 4, 4, 4};

        reset      = 1'b0;
        branch     = 1'b1;
        taken      = 1'b1;
        lookup_pc  = 32'h10;
        upd_pc     = 32'h10;
        lookup_pc2 = 32'h20;
        upd_pc2    = 32'h20;
        branch2    = 1'b0;
        taken2     = 1'b0;

        // Reset held for two edges with a live update strobe that must be ignored.
        repeat (2) tick();
        foreach (rst_pcs[i]) begin
            lookup_pc = rst_pcs[i];
            #1;
            chk($sformatf("rst_pred_%0h", rst_pcs[i]), 32'(prediction), 0);
        end
        chk("rst_cnt", 32'(mispredict_cnt), 0);
        chk("rst_mis", 32'(mispredict), 0);

        reset  = 1'b1;
        branch = 1'b0;
        #1;

`ifndef SAT_PRED_GSHARE_EN
        // Warm-up toward taken at 0x10.
        lookup_pc = 32'h10;
        upd_pc    = 32'h10;
        taken     = 1'b1;
        branch    = 1'b1;
        #1;
        chk("pre_update_pred", 32'(prediction), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("warm_pred_%0d", i), 32'(prediction), wp[i]);
            chk($sformatf("warm_mis_%0d", i), 32'(mispredict), wm[i]);
            chk($sformatf("warm_cnt_%0d", i), 32'(mispredict_cnt), wc[i]);
        end

        // Decay back to strongly not-taken.
        taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("decay_pred_%0d", i), 32'(prediction), dp[i]);
            chk($sformatf("decay_mis_%0d", i), 32'(mispredict), dm[i]);
            chk($sformatf("decay_cnt_%0d", i), 32'(mispredict_cnt), dc[i]);
        end

        // Train 0x10 to weakly taken, then probe an alias and a neighbour.
        taken = 1'b1;
        repeat (2) tick();
        chk("alias_train_mis", 32'(mispredict), 1);
        chk("alias_train_cnt", 32'(mispredict_cnt), 6);
        branch = 1'b0;
        lookup_pc = 32'h50;
        #1;
        chk("alias_pred_50", 32'(prediction), 1);
        lookup_pc = 32'h14;
        #1;
        chk("isolate_pred_14", 32'(prediction), 0);
        lookup_pc = 32'h10;

        // Idle cycles with taken wiggling must change nothing.
        for (int i = 0; i < 5; i++) begin
            taken = i[0];
            tick();
            chk($sformatf("idle_mis_%0d", i), 32'(mispredict), 0);
            chk($sformatf("idle_cnt_%0d", i), 32'(mispredict_cnt), 6);
            chk($sformatf("idle_pred_%0d", i), 32'(prediction), 1);
        end

        // One more mispredict at 0x14 so every output is non-zero before reset.
        upd_pc = 32'h14;
        taken  = 1'b1;
        branch = 1'b1;
        tick();
        branch = 1'b0;
        chk("pre_rst_mis", 32'(mispredict), 1);
        chk("pre_rst_cnt", 32'(mispredict_cnt), 7);
        chk("pre_rst_pred", 32'(prediction), 1);
`else
        // Alternating outcomes at 0x20: history separates the two phases, so misses stop.
        lookup_pc = 32'h20;
        upd_pc    = 32'h20;
        branch    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            taken = (i % 2 == 0);
            tick();
            if (i == 7) chk("gshare_cnt_8", 32'(mispredict_cnt), 4);
        end
        branch = 1'b0;
        chk("gshare_cnt_16", 32'(mispredict_cnt), 4);
        chk("gshare_mis_16", 32'(mispredict), 0);
        chk("gshare_pred", 32'(prediction), 1);

        for (int i = 0; i < 5; i++) begin
            taken = i[0];
            tick();
            chk($sformatf("idle_cnt_%0d", i), 32'(mispredict_cnt), 4);
            chk($sformatf("idle_pred_%0d", i), 32'(prediction), 1);
        end
`endif

        // Asynchronous reset pulse between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_pred", 32'(prediction), 0);
        chk("midrst_mis", 32'(mispredict), 0);
        chk("midrst_cnt", 32'(mispredict_cnt), 0);
        tick();
        reset = 1'b1;
        #1;

        // Narrow statistics counter on the second instance.
        branch2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            taken2 = (i % 2 == 0);
            tick();
`ifndef SAT_PRED_GSHARE_EN
            if (i == 2) chk("sat2_cnt_3", 32'(mispredict_cnt2), 3);
`else
            if (i == 2) chk("sat2_cnt_3", 32'(mispredict_cnt2), 2);
`endif
        end
        branch2 = 1'b0;
        chk("sat2_cnt_6", 32'(mispredict_cnt2), 3);
`ifndef SAT_PRED_GSHARE_EN
        chk("sat2_mis_6", 32'(mispredict2), 1);
`else
        chk("sat2_mis_6", 32'(mispredict2), 0);
`endif
        tick();
        chk("sat2_mis_idle", 32'(mispredict2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
